ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-master arbiter and sequencer for port A of the 16 x 42-bit dual-port register RAM. It sits between the Wishbone slave front-end (master 0) and the SPI transfer engine (master 1). It serialises their single-word read/write requests onto the RAM, absorbs the RAM's one-cycle registered read latency, and returns data with a single-cycle acknowledge. RAM port B is not driven by this block.

## Interface
Parameters:
- AW, 5: RAM address width.
- DW, 42: RAM data width.
- DEPTH, 16: number of implemented RAM words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  in  AW  word address; stable while req is high.
- m0_wdata, m1_wdata  in  DW  write data; stable while req is high.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  asserted together with ack for an out-of-range address.
- m0_rdata, m1_rdata  out  DW  registered read data; holds its value until that master's next completion.
- ram_en  out  1  to RAM ena.
- ram_we  out  1  to RAM wea.
- ram_addr  out  AW  to RAM addra.
- ram_wdata  out  DW  to RAM dia.
- ram_rdata  in  DW  from RAM doa.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP. Reset state is IDLE.
- IDLE: if no req is high, remain in IDLE. Otherwise grant one master:
  - If only one master requests, grant it.
  - If both request, grant the master not served last. The last-served pointer resets to "m1", so m0 wins the first tie.
  - The pointer updates on every grant, including error grants.
  - On grant, latch we/addr/wdata and the grant id.
  - If addr < DEPTH, go to ACCESS. Otherwise go to RESP with the error flag set.
- ACCESS: ram_en=1, with ram_we/ram_addr/ram_wdata taken from the latch. Go to WAIT.
- WAIT: ram_en=0; RAM output becomes valid. Go to RESP.
- RESP: pulse the granted master's ack for one cycle.
  - For non-error completions, load that master's rdata from ram_rdata captured in WAIT. Writes return the pre-write contents, because the RAM is read-first.
  - For error completions, assert err with ack and leave rdata unchanged.
  - Go to IDLE.
- The non-granted master's request waits untouched; there is no pre-emption.
- ram_en, ram_we, ram_addr and ram_wdata are registered outputs. ram_addr and ram_wdata hold their last value when ram_en=0.
- Reset (any time, including mid-transaction):
  - FSM goes to IDLE.
  - All outputs go to 0: ack, err, rdata and the ram_* outputs.
  - The pointer resets to m1.
  - The in-flight transaction is dropped with no ack. The RAM contents are whatever the RAM already holds.

## Timing
- Request first seen high in IDLE in cycle 0:
  - In-range: ram_en high in cycle 1, ack (and rdata valid) in cycle 3. Latency is 3 cycles for reads and writes alike.
  - Out-of-range: ack+err in cycle 1; ram_en never asserted.
- The requester must drop req in the cycle after ack. The FSM is back in IDLE that cycle, and a req still high is a new transaction.
- Back-to-back throughput: one in-range transaction per 4 cycles (RESP→IDLE→grant).
- At most one ack is high per cycle; m0_ack and m1_ack are never high together.

## Test plan
- Reset: hold rst_n=0 with random inputs → every output is 0. Release rst_n with no req → ram_en stays 0.
- Write/read: m0 writes 0x2AAAAAAAAAA to addr 3, then reads addr 3.
  - Write: ram_en/ram_we high in cycle 1, ack in cycle 3.
  - Read: m0_rdata=0x2AAAAAAAAAA with ack in cycle 3, m0_err=0.
- Read-first write: addr 5 holds 0x1; m1 writes 0x2 to addr 5 → m1_rdata=0x1 at ack; a following read of addr 5 returns 0x2.
- Tie arbitration: after reset, both masters keep requesting reads (re-raising req after each ack) → grant order m0,m1,m0,m1. Each ack is 4 cycles apart, and there is never a double ack.
- Out-of-range: m1 reads addr 20 → m1_ack and m1_err in cycle 1, ram_en stays 0, m1_rdata unchanged.
- Reset mid-op: assert rst_n during ACCESS → outputs are 0 immediately and no ack appears. After release, a read of addr 3 completes normally in 3 cycles.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: two-master single-word request/ack bus into the RAM port arbiter
interface ram_port_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 42
);
   logic          m0_req, m1_req, m0_we, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata
   );
   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
      output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises two masters onto RAM port A, absorbing its registered read latency
module ram_port_arbiter #(
   parameter int AW    = 5,
   parameter int DW    = 42,
   parameter int DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ram_port_arbiter_if.slave    bus,
   output logic                 ram_en_o,
   output logic                 ram_we_o,
   output logic [AW-1:0]        ram_addr_o,
   output logic [DW-1:0]        ram_wdata_o,
   input  logic [DW-1:0]        ram_rdata_i
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t        state_q;
   logic          last_q, gnt_q, ram_en_q, ram_we_q;
   logic [1:0]    ack_q, err_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q, rdata0_q, rdata1_q;
   logic          gnt_d, we_d, oor_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;
   // On a tie the master not served last wins
   always_comb begin
      gnt_d   = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
      we_d    = gnt_d ? bus.m1_we : bus.m0_we;
      addr_d  = gnt_d ? bus.m1_addr : bus.m0_addr;
      wdata_d = gnt_d ? bus.m1_wdata : bus.m0_wdata;
      oor_d   = {1'b0, addr_d} >= (AW+1)'(DEPTH);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         ack_q       <= '0;
         err_q       <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.m0_req || bus.m1_req) begin
               gnt_q  <= gnt_d;
               last_q <= gnt_d;
               if (oor_d) begin
                  ack_q   <= gnt_d ? 2'b10 : 2'b01;
                  err_q   <= gnt_d ? 2'b10 : 2'b01;
                  state_q <= RESP;
               end else begin
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= we_d;
                  ram_addr_q  <= addr_d;
                  ram_wdata_q <= wdata_d;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               ram_en_q <= 1'b0;
               ram_we_q <= 1'b0;
               state_q  <= WAIT;
            end
            // RAM output is valid now; capture it so rdata and ack appear together
            WAIT: begin
               ack_q <= gnt_q ? 2'b10 : 2'b01;
               if (gnt_q) rdata1_q <= ram_rdata_i;
               else rdata0_q <= ram_rdata_i;
               state_q <= RESP;
            end
            RESP: begin
               ack_q   <= '0;
               err_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.m0_ack   = ack_q[0];
   assign bus.m1_ack   = ack_q[1];
   assign bus.m0_err   = err_q[0];
   assign bus.m1_err   = err_q[1];
   assign bus.m0_rdata = rdata0_q;
   assign bus.m1_rdata = rdata1_q;
   assign ram_en_o     = ram_en_q;
   assign ram_we_o     = ram_we_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;
endmodule
